// File: rtl/multi_tone_peripheral.sv
// rtl/multi_tone_peripheral.sv - multi-channel FIFO-fed square-wave tone generator (optional MTP_LOOP_EN)
module multi_tone_peripheral #(
    parameter int NUM_CH     = 2,
    parameter int DIV_W      = 16,
    parameter int DUR_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE   = 50000,
    parameter int PIN_BASE   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  mode_i,
    input  logic [31:0] address_i,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        stall_o,
    output logic [2:0]  abort_o,
    input  logic [31:0] port_in,
    output logic [31:0] port_out,
    output logic [31:0] port_direction,
    output logic [3:0]  irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = DUR_W + DIV_W;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_TOP = PW'(PRESCALE - 1);
    localparam logic [31:0] PIN_MASK = ((32'd1 << (2 * NUM_CH)) - 32'd1) << PIN_BASE;
`ifdef MTP_LOOP_EN
    localparam logic LOOP_EN = 1'b1;
`else
    localparam logic LOOP_EN = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    logic                  wr_word;
    logic [31:0]           note_rd [NUM_CH];
    logic [31:0]           stat_rd [NUM_CH];
    logic [31:0]           ctl_rd  [NUM_CH];
    logic [2*NUM_CH-1:0]   pins;
    logic [NUM_CH-1:0]     irq_bits;
    logic                  rd_valid;
    logic [2:0]            rd_ch;
    logic [1:0]            rd_reg;
    logic                  unused_inputs;

    assign wr_word        = cs_i && write_i && (size_i == 2'b10);
    assign stall_o        = 1'b0;
    assign abort_o        = 3'b000;
    assign port_direction = ~PIN_MASK;
    assign irq_o          = {3'b000, |irq_bits};
    assign unused_inputs  = ^{mode_i, port_in, address_i[31:7], address_i[1:0]};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [NW-1:0]    mem [FIFO_DEPTH];
        logic [AW-1:0]    wp, rp;
        logic [CW-1:0]    cnt;
        state_t           st;
        logic [DIV_W-1:0] div_cnt, cur_div;
        logic [DUR_W-1:0] dur_cnt, cur_dur;
        logic [PW-1:0]    pre_cnt;
        logic             tone, en, irq_en, loop, ovf, done;
        logic             sel, note_wr, stat_wr, ctl_wr, flush, abort;
        logic             fifo_empty, fifo_full, note_end, pop, repush, push_ok, push_drop, push_any, finish;
        logic [NW-1:0]    head, wdata;

        assign sel        = wr_word && (address_i[6:4] == 3'(c));
        assign note_wr    = sel && (address_i[3:2] == 2'd0);
        assign stat_wr    = sel && (address_i[3:2] == 2'd1);
        assign ctl_wr     = sel && (address_i[3:2] == 2'd2);
        assign flush      = ctl_wr && data_in[3];
        assign abort      = ctl_wr && !data_in[0];
        assign fifo_empty = (cnt == '0);
        assign fifo_full  = (cnt == CW'(FIFO_DEPTH));
        assign head       = mem[rp];
        assign note_end   = (st == S_PLAY) && ((dur_cnt == '0) || ((pre_cnt == '0) && (dur_cnt == DUR_W'(1))));
        // A note end with a non-empty FIFO chains straight into the next note.
        assign pop        = !flush && !abort && !fifo_empty && (((st == S_IDLE) && en) || note_end);
        assign repush     = pop && loop;
        assign push_ok    = note_wr && !flush && !repush && (!fifo_full || pop);
        assign push_drop  = note_wr && !flush && !push_ok;
        assign push_any   = push_ok || repush;
        assign finish     = note_end && !pop && !flush && !abort && !loop;
        assign wdata      = repush ? head : {data_in[16 +: DUR_W], data_in[0 +: DIV_W]};

        always_ff @(posedge clk) begin
            if (push_any) mem[wp] <= wdata;
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                wp <= '0; rp <= '0; cnt <= '0;
                st <= S_IDLE; div_cnt <= '0; cur_div <= '0; dur_cnt <= '0; cur_dur <= '0;
                pre_cnt <= '0; tone <= 1'b0;
                en <= 1'b0; irq_en <= 1'b0; loop <= 1'b0; ovf <= 1'b0; done <= 1'b0;
            end else begin
                if (ctl_wr) begin
                    en     <= data_in[0];
                    irq_en <= data_in[1];
                    loop   <= data_in[2] & LOOP_EN;
                end
                if (push_drop) ovf <= 1'b1;
                else if (stat_wr && data_in[6]) ovf <= 1'b0;
                if (finish) done <= 1'b1;
                else if (stat_wr && data_in[7]) done <= 1'b0;

                if (flush) begin
                    wp <= '0; rp <= '0; cnt <= '0;
                end else begin
                    if (push_any) wp <= wp + 1'b1;
                    if (pop) rp <= rp + 1'b1;
                    if (push_any && !pop) cnt <= cnt + 1'b1;
                    else if (pop && !push_any) cnt <= cnt - 1'b1;
                end

                if (flush || abort) begin
                    st <= S_IDLE; tone <= 1'b0;
                end else if (pop) begin
                    st      <= S_PLAY;
                    cur_dur <= head[NW-1 -: DUR_W];
                    dur_cnt <= head[NW-1 -: DUR_W];
                    cur_div <= head[DIV_W-1:0];
                    div_cnt <= head[DIV_W-1:0];
                    pre_cnt <= PRE_TOP;
                    tone    <= 1'b0;
                end else if (note_end) begin
                    st <= S_IDLE; tone <= 1'b0;
                end else if (st == S_PLAY) begin
                    if (div_cnt == '0) begin
                        div_cnt <= cur_div;
                        tone    <= ~tone;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                    if (pre_cnt == '0) begin
                        pre_cnt <= PRE_TOP;
                        dur_cnt <= dur_cnt - 1'b1;
                    end else begin
                        pre_cnt <= pre_cnt - 1'b1;
                    end
                end
            end
        end

        assign pins[2*c +: 2] = ((st == S_PLAY) && (cur_div != '0) && (dur_cnt != '0)) ? {~tone, tone} : 2'b00;
        assign irq_bits[c]    = done & irq_en;
        assign note_rd[c]     = {16'(cur_dur), 16'(cur_div)};
        assign stat_rd[c]     = {24'd0, done, ovf, fifo_full, (st == S_PLAY), 4'(cnt)};
        assign ctl_rd[c]      = {29'd0, loop, irq_en, en};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            rd_ch    <= '0;
            rd_reg   <= '0;
        end else begin
            rd_valid <= cs_i && read_i && (size_i == 2'b10);
            if (cs_i && read_i) begin
                rd_ch  <= address_i[6:4];
                rd_reg <= address_i[3:2];
            end
        end
    end

    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_valid && (rd_ch == 3'(i))) begin
                case (rd_reg)
                    2'd0:    data_out = note_rd[i];
                    2'd1:    data_out = stat_rd[i];
                    2'd2:    data_out = ctl_rd[i];
                    default: data_out = '0;
                endcase
            end
        end
    end

    always_comb begin
        port_out = '0;
        port_out[PIN_BASE +: 2*NUM_CH] = pins;
    end
endmodule

// File: tb/tb_multi_tone_peripheral.sv
// tb/tb_multi_tone_peripheral.sv - scoreboard bench for multi_tone_peripheral (PRESCALE=4, NUM_CH=2)
module tb_multi_tone_peripheral;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs_i = 1'b0, read_i = 1'b0, write_i = 1'b0;
    logic [1:0]  size_i = 2'b10, mode_i = 2'b00;
    logic [31:0] address_i = '0, data_in = '0, port_in = '0;
    logic [31:0] data_out, port_out, port_direction;
    logic        stall_o;
    logic [2:0]  abort_o;
    logic [3:0]  irq_o;

    multi_tone_peripheral #(.NUM_CH(2), .PRESCALE(4)) dut (
        .clk(clk), .reset(reset), .cs_i(cs_i), .read_i(read_i), .write_i(write_i),
        .size_i(size_i), .mode_i(mode_i), .address_i(address_i), .data_in(data_in),
        .data_out(data_out), .stall_o(stall_o), .abort_o(abort_o), .port_in(port_in),
        .port_out(port_out), .port_direction(port_direction), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    logic rd_q = 1'b0;
    logic samp = 1'b0;

    always @(posedge clk) rd_q <= cs_i && read_i;

    // kind 0=data_out, 1=port_out, 2=irq_o, 3=port_direction
    task automatic compare_front(input int kind);
        exp_t        e;
        logic [31:0] act;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty kind=%0d", kind);
        end else begin
            e = q.pop_front();
            case (e.kind)
                0:       act = data_out;
                1:       act = port_out;
                2:       act = {28'd0, irq_o};
                default: act = port_direction;
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s actual=%h expected=%h", e.name, act, e.exp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rd_q) compare_front(0);
        if (samp) compare_front(1);
    end

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        cs_i = 1'b1; write_i = 1'b1; address_i = addr; data_in = data;
        @(posedge clk); #1;
        cs_i = 1'b0; write_i = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.kind = 0; e.exp = exp;
        q.push_back(e);
        cs_i = 1'b1; read_i = 1'b1; address_i = addr;
        @(posedge clk); #1;
        cs_i = 1'b0; read_i = 1'b0;
    endtask

    task automatic sample(input string name, input int kind, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.kind = kind; e.exp = exp;
        q.push_back(e);
        samp = 1'b1;
        @(posedge clk); #1;
        samp = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        sample("reset_pins", 1, 32'h0);
        sample("reset_irq", 2, 32'h0);
        sample("port_dir", 3, 32'hFFFF_FC3F);
        bus_read("reset_status0", 32'h04, 32'h0);
        bus_read("reset_ctl0", 32'h08, 32'h0);
        bus_read("reset_note1", 32'h10, 32'h0);

        // ch0 single note dur=3 div=2
        bus_write(32'h00, 32'h0003_0002);
        bus_write(32'h08, 32'h3);
        sample("a_before_pop", 1, 32'h0);
        sample("a_load", 1, 32'h80);
        idle(1);
        sample("a_before_toggle", 1, 32'h80);
        sample("a_toggle", 1, 32'h40);
        bus_read("a_busy", 32'h04, 32'h10);
        idle(6);
        sample("a_last_cycle", 1, 32'h40);
        sample("a_end_pins", 1, 32'h0);
        sample("a_irq_on", 2, 32'h1);
        bus_read("a_done", 32'h04, 32'h80);
        bus_write(32'h08, 32'h1);
        sample("a_irq_masked", 2, 32'h0);
        bus_write(32'h04, 32'h80);
        bus_read("a_done_w1c", 32'h04, 32'h0);

        // ch1 overflow while disabled
        for (int i = 0; i < 5; i++) bus_write(32'h10, 32'h0001_0001 + i);
        bus_read("b_full_ovf", 32'h14, 32'h64);
        bus_write(32'h14, 32'h40);
        bus_read("b_ovf_w1c", 32'h14, 32'h24);
        bus_write(32'h18, 32'h8);
        bus_read("b_flushed", 32'h14, 32'h0);
        bus_read("b_ctl", 32'h18, 32'h0);

        // ch1 gapless back-to-back notes
        bus_write(32'h10, 32'h0002_0001);
        bus_write(32'h10, 32'h0002_0003);
        bus_write(32'h18, 32'h1);
        idle(8);
        sample("c_note1_tail", 1, 32'h100);
        sample("c_note2_start", 1, 32'h200);
        bus_read("c_note2_reg", 32'h10, 32'h0002_0003);
        idle(5);
        sample("c_note2_tail", 1, 32'h100);
        sample("c_end", 1, 32'h0);
        bus_read("c_done", 32'h14, 32'h80);
        sample("c_irq_disabled", 2, 32'h0);

        // ch0 mid-note flush
        bus_write(32'h00, 32'h0005_0002);
        bus_write(32'h00, 32'h0005_0002);
        idle(1);
        sample("d_playing", 1, 32'h80);
        bus_write(32'h08, 32'h9);
        sample("d_pins", 1, 32'h0);
        bus_read("d_status", 32'h04, 32'h0);
        bus_read("d_ctl", 32'h08, 32'h1);

        // ch0 rest note
        bus_write(32'h00, 32'h0002_0000);
        sample("e_idle", 1, 32'h0);
        sample("e_rest_start", 1, 32'h0);
        bus_read("e_busy", 32'h04, 32'h10);
        idle(4);
        bus_read("e_busy_late", 32'h04, 32'h10);
        sample("e_rest_late", 1, 32'h0);
        bus_read("e_done", 32'h04, 32'h80);
        bus_write(32'h04, 32'h80);

        // reset mid-note
        bus_write(32'h00, 32'h0005_0002);
        idle(1);
        sample("r_playing", 1, 32'h80);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        sample("r_pins", 1, 32'h0);
        bus_read("r_ctl0", 32'h08, 32'h0);
        bus_read("r_status1", 32'h14, 32'h0);
        bus_read("unmapped_ch", 32'h74, 32'h0);
        bus_read("unmapped_reg", 32'h0C, 32'h0);

        // loop control on ch1
        bus_write(32'h18, 32'h4);
`ifdef MTP_LOOP_EN
        bus_read("g_loop_ctl", 32'h18, 32'h4);
`else
        bus_read("g_loop_ctl", 32'h18, 32'h0);
`endif
        bus_write(32'h10, 32'h0001_0001);
        bus_write(32'h10, 32'h0001_0002);
        bus_write(32'h18, 32'h5);
        idle(30);
`ifdef MTP_LOOP_EN
        bus_read("g_looping", 32'h14, 32'h12);
        bus_write(32'h18, 32'h1);
        idle(20);
        bus_read("g_drained", 32'h14, 32'h80);
`else
        bus_read("g_no_loop_done", 32'h14, 32'h80);
`endif

        idle(3);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
